// File: rtl/color_reg_writer.sv
// color_reg_writer
// ----------------
// Bus-side writer for the Denise colour lookup table. Register-bus writes
// to COLOR00..COLOR31 (word addresses BASE_ADDR..BASE_ADDR+31) are decoded
// and buffered in a small circular FIFO. The FIFO drains into the colour
// table write port at one entry per cycle while the port is not stalled.
//
// Optional build macro: COLOR_WR_BYPASS_EN
//   When defined, a decoded write that arrives with the FIFO empty and the
//   port not stalled goes straight to the output registers, saving one
//   cycle of latency. Otherwise every write passes through the FIFO.
//
// Parameters:
//   DEPTH     FIFO entries, power of two, 2..16
//   BASE_ADDR word address of COLOR00
//
// Ports:
//   clk         system clock, rising-edge
//   reset       asynchronous, active-high; clears all state
//   rga_strobe  register-bus write strobe, one cycle per write
//   rga_addr    register word address (byte address bits 8:1)
//   rga_data    register write data; bits 15:12 are ignored
//   wr_stall    colour-table port busy
//   cpu_wr      colour-table write enable (one-cycle pulse per write)
//   cpu_idx     colour-table write index
//   cpu_rgb     colour-table write data, R[11:8] G[7:4] B[3:0]
//   fifo_full   FIFO holds DEPTH entries (registered)
//   overflow    sticky: a decoded write was dropped because the FIFO was full
//
// Table port handshake: cpu_wr is a valid qualifier for cpu_idx/cpu_rgb and
// wr_stall is the inverse of ready, sampled at the issuing edge. A write is
// issued only from an edge where wr_stall=0; once cpu_wr=1 is showing the
// write is committed, and a wr_stall that rises during that cycle only
// blocks the next issue.

module color_reg_writer #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  BASE_ADDR = 8'hC0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rga_strobe,
  input  logic [7:0]  rga_addr,
  input  logic [15:0] rga_data,
  input  logic        wr_stall,
  output logic        cpu_wr,
  output logic [4:0]  cpu_idx,
  output logic [11:0] cpu_rgb,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry layout: {index[4:0], rgb[11:0]}
  logic [16:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          cpu_wr_q, cpu_wr_d;
  logic [4:0]    cpu_idx_q, cpu_idx_d;
  logic [11:0]   cpu_rgb_q, cpu_rgb_d;
  logic          fifo_full_q, fifo_full_d;
  logic          overflow_q, overflow_d;

  logic          decoded;
  logic [7:0]    offset;
  logic [16:0]   in_entry;
  logic [16:0]   head_entry;
  logic          pop;
  logic          push;
  logic          bypass;
  logic          drop;

  // Decode with a 9-bit compare so BASE_ADDR+31 cannot wrap.
  assign decoded  = rga_strobe &&
                    ({1'b0, rga_addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, rga_addr} <= ({1'b0, BASE_ADDR} + 9'd31));
  assign offset   = rga_addr - BASE_ADDR;
  assign in_entry = {offset[4:0], rga_data[11:0]};
  assign head_entry = mem_q[rd_ptr_q];

  assign pop = (count_q != '0) && !wr_stall;

`ifdef COLOR_WR_BYPASS_EN
  // Bypass only when nothing is queued, so strobe order is preserved.
  assign bypass = decoded && (count_q == '0) && !wr_stall;
`else
  assign bypass = 1'b0;
`endif

  // A full FIFO still accepts a push on an edge that also pops.
  assign push = decoded && !bypass && ((count_q != DEPTH_C) || pop);
  assign drop = decoded && !bypass && (count_q == DEPTH_C) && !pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cpu_wr_d    = 1'b0;
    cpu_idx_d   = cpu_idx_q;
    cpu_rgb_d   = cpu_rgb_q;
    overflow_d  = overflow_q | drop;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      cpu_wr_d  = 1'b1;
      cpu_idx_d = head_entry[16:12];
      cpu_rgb_d = head_entry[11:0];
    end else if (bypass) begin
      cpu_wr_d  = 1'b1;
      cpu_idx_d = in_entry[16:12];
      cpu_rgb_d = in_entry[11:0];
    end

    fifo_full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cpu_wr_q    <= 1'b0;
      cpu_idx_q   <= '0;
      cpu_rgb_q   <= '0;
      fifo_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cpu_wr_q    <= cpu_wr_d;
      cpu_idx_q   <= cpu_idx_d;
      cpu_rgb_q   <= cpu_rgb_d;
      fifo_full_q <= fifo_full_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign cpu_wr    = cpu_wr_q;
  assign cpu_idx   = cpu_idx_q;
  assign cpu_rgb   = cpu_rgb_q;
  assign fifo_full = fifo_full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_color_reg_writer.sv
// Testbench for color_reg_writer: directed test-plan sequences followed by
// random traffic, all checked every cycle against a queue-based model of
// the colour write path.

module tb_color_reg_writer;

  localparam int DEPTH = 4;
  localparam int BASE  = 'hC0;

  logic        clk;
  logic        reset;
  logic        rga_strobe;
  logic [7:0]  rga_addr;
  logic [15:0] rga_data;
  logic        wr_stall;
  logic        cpu_wr;
  logic [4:0]  cpu_idx;
  logic [11:0] cpu_rgb;
  logic        fifo_full;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pending table writes, and the expected output values.
  logic [16:0] exp_q[$];
  logic        m_wr;
  logic [4:0]  m_idx;
  logic [11:0] m_rgb;
  logic        m_ovf;
  int          n_issued;

  color_reg_writer #(.DEPTH(DEPTH), .BASE_ADDR(8'hC0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rga_strobe (rga_strobe),
    .rga_addr   (rga_addr),
    .rga_data   (rga_data),
    .wr_stall   (wr_stall),
    .cpu_wr     (cpu_wr),
    .cpu_idx    (cpu_idx),
    .cpu_rgb    (cpu_rgb),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".cpu_wr"}, 32'(cpu_wr), 32'(m_wr));
    check({tag, ".cpu_idx"}, 32'(cpu_idx), 32'(m_idx));
    check({tag, ".cpu_rgb"}, 32'(cpu_rgb), 32'(m_rgb));
    check({tag, ".fifo_full"}, 32'(fifo_full), 32'(exp_q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wr  = 1'b0;
    m_idx = '0;
    m_rgb = '0;
    m_ovf = 1'b0;
  endtask

  // One edge of the model: what the table should see after this edge.
  task automatic model_edge(input logic s, input int addr, input logic [15:0] data,
                            input logic stall);
    logic        hit;
    logic [16:0] ent;
    logic [16:0] head;
    logic        bypassed;
    hit      = s && (addr >= BASE) && (addr <= BASE + 31);
    ent      = {5'(addr - BASE), data[11:0]};
    m_wr     = 1'b0;
    bypassed = 1'b0;
`ifdef COLOR_WR_BYPASS_EN
    if (hit && exp_q.size() == 0 && !stall) begin
      m_wr = 1'b1; m_idx = ent[16:12]; m_rgb = ent[11:0];
      bypassed = 1'b1;
    end
`endif
    if (!bypassed) begin
      if (exp_q.size() > 0 && !stall) begin
        head  = exp_q.pop_front();
        m_wr  = 1'b1;
        m_idx = head[16:12];
        m_rgb = head[11:0];
      end
      if (hit) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(ent);
        else m_ovf = 1'b1;
      end
    end
    if (m_wr) n_issued++;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the next negedge.
  task automatic cyc(input logic s, input int addr, input logic [15:0] data,
                     input logic stall, input string tag);
    rga_strobe = s;
    rga_addr   = 8'(addr);
    rga_data   = data;
    wr_stall   = stall;
    @(posedge clk);
    model_edge(s, addr, data, stall);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 16'h0, 1'b0, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    reset      = 1'b1;
    rga_strobe = 1'b0;
    rga_addr   = '0;
    rga_data   = '0;
    wr_stall   = 1'b0;
    n_issued   = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single write
    n0 = n_issued;
    cyc(1'b1, 'hC5, 16'hF0A3, 1'b0, "single");
    idle(3, "single");
    check("single.count", 32'(n_issued - n0), 32'd1);

    // Decode bounds
    n0 = n_issued;
    cyc(1'b1, 'hBF, 16'h0111, 1'b0, "bound_lo_out");
    cyc(1'b1, 'hE0, 16'h0222, 1'b0, "bound_hi_out");
    idle(2, "bound_out");
    check("bound_out.count", 32'(n_issued - n0), 32'd0);
    cyc(1'b1, 'hC0, 16'h0333, 1'b0, "bound_c0");
    cyc(1'b1, 'hDF, 16'h0444, 1'b0, "bound_df");
    idle(3, "bound_in");

    // Stall and drain
    for (int i = 1; i <= 3; i++) cyc(1'b1, BASE + i, 16'(16'h0100 * i + i), 1'b1, "stall_fill");
    cyc(1'b0, 0, 16'h0, 1'b1, "stall_hold");
    idle(5, "stall_drain");

    // Full with simultaneous push/pop
    for (int i = 0; i < 4; i++) cyc(1'b1, BASE + 8 + i, 16'(16'h0A50 + i), 1'b1, "sim_fill");
    n0 = n_issued;
    cyc(1'b1, BASE + 12, 16'h0ABC, 1'b0, "sim_pushpop");
    idle(6, "sim_drain");
    check("sim.count", 32'(n_issued - n0), 32'd5);

    // Full and overflow
    for (int i = 0; i < 5; i++) cyc(1'b1, BASE + 16 + i, 16'(16'h0C00 + i), 1'b1, "ovf_fill");
    idle(6, "ovf_drain");

    // Reset mid-drain with a non-empty FIFO
    for (int i = 0; i < 3; i++) cyc(1'b1, BASE + 20 + i, 16'(16'h0D00 + i), 1'b1, "rst_fill");
    rga_strobe = 1'b0;
    wr_stall   = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 0, 16'h0, 1'b0);
    #1;
    check_outputs("rst_pre");
    #2;
    do_reset();
    n0 = n_issued;
    idle(4, "rst_after");
    check("rst_after.count", 32'(n_issued - n0), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic s;
      int   a;
      s = ($urandom_range(0, 1) == 1);
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : BASE + int'($urandom_range(0, 31));
      cyc(s, a, 16'($urandom), ($urandom_range(0, 9) < 3), "rand");
    end
    idle(DEPTH + 2, "rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Cycle budget guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

endmodule
